shared_counter_arbiter: RTL and testbench
=========================================

# shared_counter_arbiter

Round-robin arbiter and sequencer that shares one saturating up/down counter between `NUM_REQ` independent requesters. Each requester issues single-step increment/decrement commands over a valid/ready handshake; a separate load port re-initialises the count. The block owns the count register and publishes `count`, `at_max` and `at_min` to downstream logic. It replaces ad-hoc `up`/`down` muxing wherever several agents must adjust one shared count.

## Interface
- `WIDTH`, 8: count width in bits (≥2).
- `NUM_REQ`, 4: number of requesters (2..16).
- `INIT_VALUE`, 0: count value on reset; must fit in `WIDTH` bits.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input `NUM_REQ`: per-requester command valid.
- `req_dir` input `NUM_REQ`: per-requester direction, 1 = up, 0 = down.
- `req_ready` output `NUM_REQ`: per-requester grant; one-hot or zero.
- `load_valid` input 1: load request.
- `load_value` input `WIDTH`: value to load.
- `load_ready` output 1: load accepted this cycle.
- `hold` input 1: freeze arbitration; the count is retained.
- `grant_valid` output 1: registered; a requester command was accepted in the previous cycle.
- `grant_id` output `$clog2(NUM_REQ)`: registered; index of that requester.
- `count` output `WIDTH`: current count.
- `at_max` output 1: `count` equals all ones.
- `at_min` output 1: `count` equals 0.
- `sat_pulse` output 1: registered; the previously accepted command was blocked by saturation.

## Operation
- States are RUN, SETTLE and HOLD.
- Reset state: RUN, `count = INIT_VALUE`, round-robin pointer = 0, `grant_valid = 0`, `grant_id = 0`, `sat_pulse = 0`.
- RUN, priority order:
  - `hold` is checked first. If set, go to HOLD; `load_ready = 0` and `req_ready = 0` this cycle.
  - Otherwise, if `load_valid` is set, `load_ready = 1`, `count <= load_value`, go to SETTLE, and `req_ready = 0`.
  - Otherwise, the winner is the first `i` with `req_valid[i] = 1`, searching from the pointer upward with wrap. `req_ready[winner] = 1`.
- Accepted up command: `count + 1`, unless `count` is all ones; then `count` is unchanged and `sat_pulse` is set next cycle.
- Accepted down command: `count - 1`, unless `count` is 0; then `count` is unchanged and `sat_pulse` is set next cycle.
- After any accept, the pointer becomes `(winner + 1) mod NUM_REQ`. With no accept, the pointer is unchanged.
- SETTLE lasts exactly one cycle. No grants and no loads occur in it. The next state is HOLD if `hold` is set, else RUN.
- HOLD: no grants and no loads. Return to RUN on the first cycle `hold` is sampled low.
- Handshake rules:
  - A requester keeps `req_valid` high and `req_dir` stable until it sees `req_ready`.
  - Deasserting `req_valid` before a grant is legal and drops the request.
  - At most one command (load or requester) is accepted per cycle.
- `req_ready` and `load_ready` are combinational from the inputs, the state and the pointer. There is no combinational path from `req_ready` to `req_valid`.
- `at_max` and `at_min` are combinational from the `count` register.
- Asserting `rst` mid-operation forces the reset values asynchronously. An in-flight handshake is discarded and no grant is reported.

## Timing
- Accept in cycle N: `count` holds the new value in cycle N+1. `grant_valid`, `grant_id` and `sat_pulse` are valid in cycle N+1 for one cycle.
- Load accepted in cycle N: the new `count` is visible in N+1 (SETTLE). The earliest requester grant is in N+2.
- Throughput: one command per cycle in RUN.
- Fairness: a continuously asserted request is granted within `NUM_REQ` accepting cycles.
- `hold` is sampled on the clock edge; it affects grants in the same cycle it is high while in RUN.

## Configuration
- `SHARED_CNT_WRAP_EN` defined:
  - Up from all ones wraps to 0; down from 0 wraps to all ones.
  - `sat_pulse` is tied to 0.
  - `at_max` and `at_min` behave as in saturating mode.
- `SHARED_CNT_WRAP_EN` undefined: saturating behaviour as described above.

## Test plan
- Reset and hold-free grants, with `WIDTH=8`, `INIT_VALUE=5`:
  - Stimulus: release `rst`, then `req_valid[0]=1`, `req_dir[0]=1` for 3 cycles.
  - Required: `count` reads 6, 7, 8; `grant_id=0` each cycle; `sat_pulse=0`.
- Round-robin:
  - Stimulus: all 4 requesters valid, all up, from `count=0` and pointer 0.
  - Required: grants in order 0, 1, 2, 3, 0; `count=5` after 5 cycles.
- Saturation:
  - Stimulus: load 255, then request up; separately load 0 and request down.
  - Required: `count` stays 255 (respectively 0); `sat_pulse=1` one cycle later; `at_max` (respectively `at_min`) is high.
- Load priority and SETTLE:
  - Stimulus: `load_valid` with `load_value=100`, with `req_valid[2]` asserted in the same cycle.
  - Required: `load_ready=1`, `req_ready=0`; `count=100` next cycle; `req_ready[2]` first high 2 cycles after the load; `count=101` after that grant.
- Hold and mid-operation reset:
  - Stimulus: assert `hold` for 4 cycles with requests pending, then assert `rst` while a grant is active.
  - Required: no `req_ready` during hold and `count` unchanged; on `rst`, `count=INIT_VALUE` immediately and `grant_valid=0`.
- Wrap build (`SHARED_CNT_WRAP_EN`):
  - Stimulus: up from 255; down from 0.
  - Required: `count` becomes 0 (respectively 255); `sat_pulse` stays 0.

Source files
------------

// File: rtl/shared_counter_arbiter.sv
// Round-robin arbiter that shares one up/down counter between NUM_REQ requesters.
// Optional macro SHARED_CNT_WRAP_EN: count wraps at the ends instead of saturating.
module shared_counter_arbiter #(
    parameter int WIDTH      = 8,
    parameter int NUM_REQ    = 4,
    parameter int INIT_VALUE = 0,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_dir,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic               load_valid,
    input  logic [WIDTH-1:0]   load_value,
    output logic               load_ready,
    input  logic               hold,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic [WIDTH-1:0]   count,
    output logic               at_max,
    output logic               at_min,
    output logic               sat_pulse
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            accept;
    logic            win_dir;
    logic            blocked;

    // First valid requester at or above the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            ST_RUN: begin
                if (hold) begin
                    state_next = ST_HOLD;
                end else if (load_valid) begin
                    load_ready = 1'b1;
                    state_next = ST_SETTLE;
                end else if (found) begin
                    accept    = 1'b1;
                    req_ready = NUM_REQ'(1) << winner;
                end
            end
            ST_SETTLE: state_next = hold ? ST_HOLD : ST_RUN;
            ST_HOLD:   state_next = hold ? ST_HOLD : ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    assign win_dir  = req_dir[winner];
    assign at_max   = &count;
    assign at_min   = ~|count;
    assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef SHARED_CNT_WRAP_EN
    assign blocked = 1'b0;
`else
    // A step past either end is swallowed and reported one cycle later.
    assign blocked = win_dir ? at_max : at_min;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= WIDTH'(INIT_VALUE);
            ptr         <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            sat_pulse   <= 1'b0;
        end else begin
            grant_valid <= accept;
            sat_pulse   <= accept && blocked;
            if (accept) begin
                grant_id <= winner;
                ptr      <= ptr_next;
            end
            if (load_ready) begin
                count <= load_value;
            end else if (accept && !blocked) begin
                count <= win_dir ? count + 1'b1 : count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Self-checking bench for shared_counter_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the counter and round-robin rules.
module tb_shared_counter_arbiter;

    localparam int WIDTH      = 8;
    localparam int NUM_REQ    = 4;
    localparam int INIT_VALUE = 5;
    localparam int MAXV       = (1 << WIDTH) - 1;
`ifdef SHARED_CNT_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_REQ-1:0] req_valid = '0;
    logic [NUM_REQ-1:0] req_dir = '0;
    logic [NUM_REQ-1:0] req_ready;
    logic               load_valid = 1'b0;
    logic [WIDTH-1:0]   load_value = '0;
    logic               load_ready;
    logic               hold = 1'b0;
    logic               grant_valid;
    logic [1:0]         grant_id;
    logic [WIDTH-1:0]   count;
    logic               at_max;
    logic               at_min;
    logic               sat_pulse;

    shared_counter_arbiter #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .INIT_VALUE(INIT_VALUE)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
        .load_valid(load_valid), .load_value(load_value), .load_ready(load_ready),
        .hold(hold), .grant_valid(grant_valid), .grant_id(grant_id),
        .count(count), .at_max(at_max), .at_min(at_min), .sat_pulse(sat_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: plain integers; "settling" and "holding" describe what the block is doing.
    int           m_count;
    int           m_ptr;
    bit           m_settling;
    bit           m_holding;
    bit           m_gv;
    bit           m_sat;
    int           m_gid;
    logic [3:0]   exp_rr;
    logic [3:0]   obs_rr;
    logic         exp_lr;
    logic         obs_lr;

    task automatic model_reset();
        m_count = INIT_VALUE; m_ptr = 0; m_settling = 0; m_holding = 0;
        m_gv = 0; m_sat = 0; m_gid = 0;
    endtask

    // Drives one cycle (entered and left at posedge+1), captures ready outputs before the edge.
    task automatic step(input logic [3:0] v, input logic [3:0] d, input logic lv,
                        input int lval, input logic h);
        int w;
        int idx;
        bit can_act;
        req_valid = v; req_dir = d; load_valid = lv; load_value = WIDTH'(lval); hold = h;
        can_act = !m_settling && !m_holding && !h;
        w = -1; exp_rr = '0; exp_lr = 1'b0;
        if (can_act && lv) begin
            exp_lr = 1'b1;
        end else if (can_act) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                idx = (m_ptr + off) % NUM_REQ;
                if (w < 0 && v[2'(idx)]) w = idx;
            end
        end
        if (w >= 0) exp_rr[2'(w)] = 1'b1;
        @(negedge clk);
        obs_rr = req_ready;
        obs_lr = load_ready;
        @(posedge clk);
        #1;
        m_gv = 0; m_sat = 0;
        if (!m_settling && !m_holding) begin
            if (h) begin
                m_holding = 1;
            end else if (lv) begin
                m_count = lval; m_settling = 1;
            end else if (w >= 0) begin
                m_gv = 1; m_gid = w; m_ptr = (w + 1) % NUM_REQ;
                if (d[2'(w)]) begin
                    if (m_count < MAXV) m_count = m_count + 1;
                    else if (WRAP) m_count = 0;
                    else m_sat = 1;
                end else begin
                    if (m_count > 0) m_count = m_count - 1;
                    else if (WRAP) m_count = MAXV;
                    else m_sat = 1;
                end
            end
        end else begin
            m_settling = 0;
            m_holding  = h;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; req_valid = '0; req_dir = '0; load_valid = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int exp_counts [3] = '{6, 7, 8};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 8'(INIT_VALUE)) begin n_fail++; $display("FAIL reset_count: got %0d expected %0d", count, INIT_VALUE); end
        n_checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0 || sat_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs: got gv=%0b id=%0d sat=%0b expected 0 0 0", grant_valid, grant_id, sat_pulse);
        end
        n_checks++; if (at_max !== 1'b0 || at_min !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got max=%0b min=%0b expected 0 0", at_max, at_min); end
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            step(4'b0001, 4'b0001, 1'b0, 0, 1'b0);
            n_checks++; if (obs_rr !== 4'b0001) begin n_fail++; $display("FAIL first_ready[%0d]: got %b expected 0001", n, obs_rr); end
            n_checks++; if (count !== 8'(exp_counts[n])) begin n_fail++; $display("FAIL first_count[%0d]: got %0d expected %0d", n, count, exp_counts[n]); end
            n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0 || sat_pulse !== 1'b0) begin
                n_fail++; $display("FAIL first_grant[%0d]: got gv=%0b id=%0d sat=%0b expected 1 0 0", n, grant_valid, grant_id, sat_pulse);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_ids [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);
        n_checks++; if (obs_lr !== 1'b1) begin n_fail++; $display("FAIL rr_load_ready: got %0b expected 1", obs_lr); end
        step(4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            step(4'b1111, 4'b1111, 1'b0, 0, 1'b0);
            n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'(exp_ids[n])) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got gv=%0b id=%0d expected 1 %0d", n, grant_valid, grant_id, exp_ids[n]);
            end
        end
        n_checks++; if (count !== 8'd5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", count); end
    endtask

    task automatic test_saturation();
        int exp_c;
        step(4'b0000, 4'b0000, 1'b1, MAXV, 1'b0);
        step(4'b0010, 4'b0010, 1'b0, 0, 1'b0);
        n_checks++; if (obs_rr !== 4'b0000) begin n_fail++; $display("FAIL settle_no_grant: got %b expected 0000", obs_rr); end
        step(4'b0010, 4'b0010, 1'b0, 0, 1'b0);
        exp_c = WRAP ? 0 : MAXV;
        n_checks++; if (count !== 8'(exp_c) || sat_pulse !== !WRAP) begin
            n_fail++; $display("FAIL sat_up: got count=%0d sat=%0b expected %0d %0b", count, sat_pulse, exp_c, !WRAP);
        end
        n_checks++; if (at_max !== (exp_c == MAXV) || at_min !== (exp_c == 0)) begin
            n_fail++; $display("FAIL sat_up_flags: got max=%0b min=%0b expected %0b %0b", at_max, at_min, exp_c == MAXV, exp_c == 0);
        end
        step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);
        n_checks++; if (sat_pulse !== 1'b0) begin n_fail++; $display("FAIL sat_one_cycle: got %0b expected 0", sat_pulse); end
        step(4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        step(4'b1000, 4'b0000, 1'b0, 0, 1'b0);
        exp_c = WRAP ? MAXV : 0;
        n_checks++; if (count !== 8'(exp_c) || sat_pulse !== !WRAP) begin
            n_fail++; $display("FAIL sat_down: got count=%0d sat=%0b expected %0d %0b", count, sat_pulse, exp_c, !WRAP);
        end
        n_checks++; if (at_min !== (exp_c == 0) || at_max !== (exp_c == MAXV)) begin
            n_fail++; $display("FAIL sat_down_flags: got min=%0b max=%0b expected %0b %0b", at_min, at_max, exp_c == 0, exp_c == MAXV);
        end
    endtask

    task automatic test_load_priority();
        step(4'b0100, 4'b0100, 1'b1, 100, 1'b0);
        n_checks++; if (obs_lr !== 1'b1 || obs_rr !== 4'b0000) begin
            n_fail++; $display("FAIL load_prio: got lr=%0b rr=%b expected 1 0000", obs_lr, obs_rr);
        end
        n_checks++; if (count !== 8'd100) begin n_fail++; $display("FAIL load_count: got %0d expected 100", count); end
        step(4'b0100, 4'b0100, 1'b0, 0, 1'b0);
        n_checks++; if (obs_rr !== 4'b0000) begin n_fail++; $display("FAIL load_settle: got %b expected 0000", obs_rr); end
        step(4'b0100, 4'b0100, 1'b0, 0, 1'b0);
        n_checks++; if (obs_rr !== 4'b0100 || count !== 8'd101) begin
            n_fail++; $display("FAIL load_then_grant: got rr=%b count=%0d expected 0100 101", obs_rr, count);
        end
    endtask

    task automatic test_hold_and_reset();
        step(4'b0000, 4'b0000, 1'b1, 42, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            step(4'b1011, 4'b1111, n[0], 7, 1'b1);
            n_checks++; if (obs_rr !== 4'b0000 || obs_lr !== 1'b0 || count !== 8'd42) begin
                n_fail++; $display("FAIL hold[%0d]: got rr=%b lr=%0b count=%0d expected 0000 0 42", n, obs_rr, obs_lr, count);
            end
        end
        step(4'b1011, 4'b1111, 1'b0, 0, 1'b0);
        n_checks++; if (obs_rr !== 4'b0000) begin n_fail++; $display("FAIL hold_exit: got %b expected 0000", obs_rr); end
        step(4'b1011, 4'b1111, 1'b0, 0, 1'b0);
        n_checks++; if (obs_rr !== exp_rr || count !== 8'(m_count)) begin
            n_fail++; $display("FAIL hold_resume: got rr=%b count=%0d expected %b %0d", obs_rr, count, exp_rr, m_count);
        end
        req_valid = 4'b1111; req_dir = 4'b1111;
        #2;
        n_checks++; if (req_ready === 4'b0000) begin n_fail++; $display("FAIL pre_reset_grant: got %b expected nonzero", req_ready); end
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 8'(INIT_VALUE) || grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got count=%0d gv=%0b expected %0d 0", count, grant_valid, INIT_VALUE);
        end
        @(posedge clk);
        #1;
        n_checks++; if (count !== 8'(INIT_VALUE) || grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_held: got count=%0d gv=%0b expected %0d 0", count, grant_valid, INIT_VALUE);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [3:0] v = '0;
        logic [3:0] d = '0;
        logic       lv;
        logic       h;
        int         lval;
        int         edge_vals [4] = '{0, 1, MAXV - 1, MAXV};
        obs_rr = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (obs_rr[2'(i)] || !v[2'(i)]) begin
                    v[2'(i)] = 1'($urandom_range(0, 1));
                    d[2'(i)] = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 15) == 0) begin
                    v[2'(i)] = 1'b0;
                end
            end
            lv   = ($urandom_range(0, 9) == 0);
            h    = ($urandom_range(0, 7) == 0);
            lval = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 3)] : int'($urandom_range(0, MAXV));
            step(v, d, lv, lval, h);
            n_checks++; if (obs_rr !== exp_rr || obs_lr !== exp_lr) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got rr=%b lr=%0b expected %b %0b", n, obs_rr, obs_lr, exp_rr, exp_lr);
            end
            n_checks++; if (count !== 8'(m_count) || at_max !== (m_count == MAXV) || at_min !== (m_count == 0)) begin
                n_fail++; $display("FAIL rnd_count[%0d]: got %0d max=%0b min=%0b expected %0d", n, count, at_max, at_min, m_count);
            end
            n_checks++; if (grant_valid !== m_gv || sat_pulse !== m_sat || (m_gv && grant_id !== 2'(m_gid))) begin
                n_fail++; $display("FAIL rnd_grant[%0d]: got gv=%0b id=%0d sat=%0b expected %0b %0d %0b",
                                   n, grant_valid, grant_id, sat_pulse, m_gv, m_gid, m_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_saturation();
        test_load_priority();
        test_hold_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
